hi_reader_seq: RTL and testbench

HF reader transaction sequencer that drives the reader datapath's `minor_mode` and `ssp_dout` modulation input. It runs one request/response exchange per command: modulate a bit pattern onto the 13.56 MHz carrier, hold a guard interval, then open a bounded receive window. It sits between the ARM command registers and the reader correlator/antenna-driver block, on the carrier clock domain.

---
 rtl/hi_reader_pkg.sv | 40 ++++
 rtl/hi_reader_seq_bit_tx.sv | 60 ++++++
 rtl/hi_reader_seq.sv | 186 ++++++++++++++++++
 tb/tb_hi_reader_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_reader_pkg.sv
// Shared constants, state and status types for the HF reader sequencer.
// The SNIFF state exists only when HI_READER_SEQ_SNIFF_EN is defined.
package hi_reader_pkg;

  localparam logic [2:0] RECEIVE_IQ        = 3'd0;
  localparam logic [2:0] RECEIVE_AMPLITUDE = 3'd1;
  localparam logic [2:0] RECEIVE_PHASE     = 3'd2;
  localparam logic [2:0] SEND_FULL_MOD     = 3'd3;
  localparam logic [2:0] SEND_SHALLOW_MOD  = 3'd4;
  localparam logic [2:0] SNIFF_IQ          = 3'd5;
  localparam logic [2:0] SNIFF_AMPLITUDE   = 3'd6;
  localparam logic [2:0] SNIFF_PHASE       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_GUARD,
    S_RX
`ifdef HI_READER_SEQ_SNIFF_EN
    , S_SNIFF
`endif
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_TIMEOUT,
    ST_STOPPED,
    ST_ABORTED
  } status_t;

  // Only the three receive codes are legal in GUARD/RX.
  function automatic logic [2:0] sanitize_rx(input logic [2:0] m);
    return (m <= RECEIVE_PHASE) ? m : RECEIVE_IQ;
  endfunction

  function automatic logic [2:0] sanitize_sniff(input logic [2:0] m);
    return (m >= SNIFF_IQ) ? m : SNIFF_IQ;
  endfunction

endpackage

// File: rtl/hi_reader_seq_bit_tx.sv
// Bit serialiser: 32-bit LSB-first shift register, per-bit timer and bit counter.
// last flags the final carrier cycle of the final bit.
module hi_reader_bit_tx #(
  parameter int BIT_CYCLES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  logic [5:0]  len,
  input  logic [31:0] data,
  output logic        tx_mod,
  output logic        last
);
  import hi_reader_pkg::*;

  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(BIT_CYCLES - 1);

  logic [31:0]   sreg;
  logic [TW-1:0] timer;
  logic [5:0]    count;
  logic [5:0]    len_q;
  logic          active;
  logic          bit_end;
  logic          final_bit;

  assign bit_end   = (timer == T_MAX);
  assign final_bit = (count == len_q - 6'd1);
  assign last      = active & bit_end & final_bit;
  assign tx_mod    = active & sreg[0];

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      sreg   <= '0;
      timer  <= '0;
      count  <= '0;
      len_q  <= '0;
      active <= 1'b0;
    end else if (clear) begin
      active <= 1'b0;
    end else if (load) begin
      sreg   <= data;
      timer  <= '0;
      count  <= '0;
      len_q  <= len;
      active <= (len != 6'd0);
    end else if (active) begin
      if (bit_end) begin
        timer <= '0;
        sreg  <= sreg >> 1;
        count <= count + 6'd1;
        if (final_bit) active <= 1'b0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/hi_reader_seq.sv
// HF reader transaction sequencer: TX modulation, guard interval, bounded RX window.
// Optional sniff mode is enabled with HI_READER_SEQ_SNIFF_EN.
module hi_reader_seq #(
  parameter int BIT_CYCLES = 128
) (
  input  logic        ck_1356meg,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_tx_data,
  input  logic [5:0]  cmd_tx_len,
  input  logic        cmd_full_mod,
  input  logic [2:0]  cmd_rx_mode,
  input  logic [15:0] cmd_guard,
  input  logic [15:0] cmd_rx_window,
  input  logic        rx_stop,
  input  logic        abort,
  input  logic        sniff_req,
  input  logic [2:0]  sniff_mode,
  output logic [2:0]  minor_mode,
  output logic        tx_mod,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status
);
  import hi_reader_pkg::*;

  state_t      state, state_n;
  status_t     status_q, status_n;
  logic [15:0] phase, phase_n;
  logic [15:0] guard_q, guard_n;
  logic [15:0] window_q, window_n;
  logic [2:0]  rx_mode_q, rx_mode_n;
  logic        full_q, full_n;
  logic        done_n;
  logic [2:0]  mode_n;
  logic        accept;
  logic        tx_last;

`ifndef HI_READER_SEQ_SNIFF_EN
  logic unused_sniff;
  assign unused_sniff = ^{sniff_req, sniff_mode};
`endif

  // Valid/ready: a command transfers on any falling edge where cmd_valid and
  // cmd_ready are both high; abort withdraws ready so it blocks the transfer.
  assign cmd_ready = reset_n & ~abort & (state == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != S_IDLE);
  assign status    = status_q;

  assign guard_n   = accept ? cmd_guard : guard_q;
  assign window_n  = accept ? cmd_rx_window : window_q;
  assign rx_mode_n = accept ? sanitize_rx(cmd_rx_mode) : rx_mode_q;
  assign full_n    = accept ? cmd_full_mod : full_q;

  hi_reader_bit_tx #(.BIT_CYCLES(BIT_CYCLES)) u_bit_tx (
    .clk     (ck_1356meg),
    .reset_n (reset_n),
    .load    (accept),
    .clear   (abort),
    .len     (cmd_tx_len),
    .data    (cmd_tx_data),
    .tx_mod  (tx_mod),
    .last    (tx_last)
  );

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    status_n = status_q;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_tx_len != 6'd0) begin
            state_n = S_TX;
          end else if (cmd_guard != 16'd0) begin
            state_n = S_GUARD;
            phase_n = cmd_guard;
          end else begin
            state_n = S_RX;
            phase_n = cmd_rx_window;
          end
        end
`ifdef HI_READER_SEQ_SNIFF_EN
        else if (sniff_req && !abort) begin
          state_n = S_SNIFF;
        end
`endif
      end
      S_TX: begin
        if (abort) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_ABORTED;
        end else if (tx_last) begin
          if (guard_q != 16'd0) begin
            state_n = S_GUARD;
            phase_n = guard_q;
          end else begin
            state_n = S_RX;
            phase_n = window_q;
          end
        end
      end
      S_GUARD: begin
        if (abort) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_ABORTED;
        end else if (phase <= 16'd1) begin
          state_n = S_RX;
          phase_n = window_q;
        end else begin
          phase_n = phase - 16'd1;
        end
      end
      S_RX: begin
        // A zero window never decrements, so it cannot reach expiry.
        if (abort) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_ABORTED;
        end else if (rx_stop) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_STOPPED;
        end else if (window_q != 16'd0) begin
          if (phase <= 16'd1) begin
            state_n  = S_IDLE;
            done_n   = 1'b1;
            status_n = ST_TIMEOUT;
          end else begin
            phase_n = phase - 16'd1;
          end
        end
      end
`ifdef HI_READER_SEQ_SNIFF_EN
      S_SNIFF: begin
        if (abort || !sniff_req) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // minor_mode is registered from the next state so it switches with the state.
  always_comb begin
    mode_n = RECEIVE_IQ;
    case (state_n)
      S_TX:    mode_n = full_n ? SEND_FULL_MOD : SEND_SHALLOW_MOD;
      S_GUARD: mode_n = rx_mode_n;
      S_RX:    mode_n = rx_mode_n;
`ifdef HI_READER_SEQ_SNIFF_EN
      S_SNIFF: mode_n = sanitize_sniff(sniff_mode);
`endif
      default: mode_n = RECEIVE_IQ;
    endcase
  end

  always_ff @(negedge ck_1356meg) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      status_q   <= ST_NONE;
      phase      <= '0;
      guard_q    <= '0;
      window_q   <= '0;
      rx_mode_q  <= RECEIVE_IQ;
      full_q     <= 1'b0;
      done       <= 1'b0;
      minor_mode <= RECEIVE_IQ;
    end else begin
      state      <= state_n;
      status_q   <= status_n;
      phase      <= phase_n;
      guard_q    <= guard_n;
      window_q   <= window_n;
      rx_mode_q  <= rx_mode_n;
      full_q     <= full_n;
      done       <= done_n;
      minor_mode <= mode_n;
    end
  end

endmodule

// File: tb/tb_hi_reader_seq.sv
// Directed bench for hi_reader_seq with BIT_CYCLES=4; sniff checks follow
// HI_READER_SEQ_SNIFF_EN.
module tb_hi_reader_seq;

  logic        ck_1356meg;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_tx_data;
  logic [5:0]  cmd_tx_len;
  logic        cmd_full_mod;
  logic [2:0]  cmd_rx_mode;
  logic [15:0] cmd_guard;
  logic [15:0] cmd_rx_window;
  logic        rx_stop;
  logic        abort;
  logic        sniff_req;
  logic [2:0]  sniff_mode;
  logic [2:0]  minor_mode;
  logic        tx_mod;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] d;

  hi_reader_seq #(.BIT_CYCLES(4)) dut (
    .ck_1356meg    (ck_1356meg),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_tx_data   (cmd_tx_data),
    .cmd_tx_len    (cmd_tx_len),
    .cmd_full_mod  (cmd_full_mod),
    .cmd_rx_mode   (cmd_rx_mode),
    .cmd_guard     (cmd_guard),
    .cmd_rx_window (cmd_rx_window),
    .rx_stop       (rx_stop),
    .abort         (abort),
    .sniff_req     (sniff_req),
    .sniff_mode    (sniff_mode),
    .minor_mode    (minor_mode),
    .tx_mod        (tx_mod),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  // Clock and watchdog
  initial begin
    ck_1356meg = 1'b0;
    forever #5 ck_1356meg = ~ck_1356meg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: DUT updates on the falling edge, bench acts 1 ns after rising edge.
  task automatic step();
    @(posedge ck_1356meg);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] len, input logic [31:0] data, input logic full,
                       input logic [2:0] rxm, input logic [15:0] grd, input logic [15:0] win);
    cmd_valid     = 1'b1;
    cmd_tx_len    = len;
    cmd_tx_data   = data;
    cmd_full_mod  = full;
    cmd_rx_mode   = rxm;
    cmd_guard     = grd;
    cmd_rx_window = win;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_tx_data = '0; cmd_tx_len = '0;
    cmd_full_mod = 1'b0; cmd_rx_mode = '0; cmd_guard = '0; cmd_rx_window = '0;
    rx_stop = 1'b0; abort = 1'b0; sniff_req = 1'b0; sniff_mode = '0;

    // Reset state
    step(); step(); step();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", minor_mode, 0);
    chk("rst_tx", tx_mod, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", cmd_ready, 1);

    // T1: len4 data 1010 full, guard10, window20 -> done status1 at N+47
    d = 32'hA;
    issue(6'd4, d, 1'b1, 3'd0, 16'd10, 16'd20);
    chk("t1_ready", cmd_ready, 1);
    for (int c = 1; c <= 47; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c < 47) begin
        chk($sformatf("t1_tx_c%0d", c), tx_mod, (c <= 16) ? d[(c-1)/4] : 1'b0);
        chk($sformatf("t1_mode_c%0d", c), minor_mode, (c <= 16) ? 3 : 0);
        chk($sformatf("t1_done_c%0d", c), done, 0);
        chk($sformatf("t1_busy_c%0d", c), busy, 1);
      end else begin
        chk("t1_done", done, 1);
        chk("t1_status", status, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_ready_end", cmd_ready, 1);
      end
    end

    // T2 back-to-back in the done cycle: unbounded RX, rx_mode1, stop at N+100
    issue(6'd0, 32'h0, 1'b0, 3'd1, 16'd0, 16'd0);
    for (int c = 1; c <= 101; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c <= 100) begin
        chk($sformatf("t2_mode_c%0d", c), minor_mode, 1);
        chk($sformatf("t2_done_c%0d", c), done, 0);
        if (c == 100) rx_stop = 1'b1;
      end else begin
        chk("t2_done", done, 1);
        chk("t2_status", status, 2);
        chk("t2_mode_end", minor_mode, 0);
        rx_stop = 1'b0;
      end
    end

    // T3: abort during TX bit 2; cmd_valid during abort in IDLE is refused
    step();
    d = 32'h4;
    issue(6'd4, d, 1'b1, 3'd0, 16'd5, 16'd5);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      chk($sformatf("t3_tx_c%0d", c), tx_mod, d[(c-1)/4]);
    end
    abort = 1'b1;
    issue(6'd0, 32'h0, 1'b0, 3'd0, 16'd0, 16'd3);
    step();
    chk("t3_tx_abort", tx_mod, 0);
    chk("t3_mode_abort", minor_mode, 0);
    chk("t3_done", done, 1);
    chk("t3_status", status, 3);
    chk("t3_busy", busy, 0);
    chk("t3_ready_abort", cmd_ready, 0);
    step();
    chk("t3_not_accepted", busy, 0);
    chk("t3_no_done", done, 0);
    chk("t3_status_hold", status, 3);
    abort = 1'b0;
    cmd_valid = 1'b0;

    // T4: rx_mode6 sanitised to 0; rx_stop on final window cycle -> STOPPED
    step();
    issue(6'd0, 32'h0, 1'b0, 3'd6, 16'd3, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c <= 7) begin
        chk($sformatf("t4_mode_c%0d", c), minor_mode, 0);
        chk($sformatf("t4_busy_c%0d", c), busy, 1);
        if (c == 7) rx_stop = 1'b1;
      end else begin
        chk("t4_done", done, 1);
        chk("t4_status", status, 2);
        rx_stop = 1'b0;
      end
    end

    // T4b back-to-back: rx_mode2, guard2, window3 -> TIMEOUT at +6
    issue(6'd0, 32'h0, 1'b0, 3'd2, 16'd2, 16'd3);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c <= 5) begin
        chk($sformatf("t4b_mode_c%0d", c), minor_mode, 2);
        chk($sformatf("t4b_done_c%0d", c), done, 0);
      end else begin
        chk("t4b_done", done, 1);
        chk("t4b_status", status, 1);
        chk("t4b_mode_end", minor_mode, 0);
      end
    end

    // T5 back-to-back: len32 shallow, window1 -> done at +130
    d = 32'h8000_0001;
    issue(6'd32, d, 1'b0, 3'd1, 16'd0, 16'd1);
    for (int c = 1; c <= 130; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c <= 128) begin
        chk($sformatf("t5_tx_c%0d", c), tx_mod, d[(c-1)/4]);
        chk($sformatf("t5_mode_c%0d", c), minor_mode, 4);
      end else if (c == 129) begin
        chk("t5_rx_mode", minor_mode, 1);
        chk("t5_rx_tx", tx_mod, 0);
        chk("t5_rx_done", done, 0);
      end else begin
        chk("t5_done", done, 1);
        chk("t5_status", status, 1);
      end
    end

    // T6: reset mid-RX, then a fresh command is accepted normally
    step();
    issue(6'd0, 32'h0, 1'b1, 3'd2, 16'd0, 16'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      chk($sformatf("t6_mode_c%0d", c), minor_mode, 2);
    end
    reset_n = 1'b0;
    chk("t6_ready_in_rst", cmd_ready, 0);
    step();
    chk("t6_rst_mode", minor_mode, 0);
    chk("t6_rst_tx", tx_mod, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_status", status, 0);
    reset_n = 1'b1;
    step();
    chk("t6_ready_after", cmd_ready, 1);
    chk("t6_no_done", done, 0);
    issue(6'd1, 32'h1, 1'b1, 3'd0, 16'd0, 16'd2);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      if (c <= 4) begin
        chk($sformatf("t6_tx_c%0d", c), tx_mod, 1);
        chk($sformatf("t6_mode_c%0d", c + 5), minor_mode, 3);
      end else if (c <= 6) begin
        chk($sformatf("t6_rx_tx_c%0d", c), tx_mod, 0);
        chk($sformatf("t6_rx_busy_c%0d", c), busy, 1);
      end else begin
        chk("t6_done", done, 1);
        chk("t6_status", status, 1);
      end
    end

    // T7: sniff request
    step();
    sniff_req = 1'b1;
    sniff_mode = 3'd6;
    step();
`ifdef HI_READER_SEQ_SNIFF_EN
    chk("t7_sniff_mode", minor_mode, 6);
    chk("t7_sniff_ready", cmd_ready, 0);
    chk("t7_sniff_busy", busy, 1);
`else
    chk("t7_sniff_mode", minor_mode, 0);
    chk("t7_sniff_ready", cmd_ready, 1);
    chk("t7_sniff_busy", busy, 0);
`endif
    sniff_req = 1'b0;
    step();
    chk("t7_exit_busy", busy, 0);
    chk("t7_exit_done", done, 0);
    chk("t7_exit_mode", minor_mode, 0);
    chk("t7_exit_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
